// File: rtl/adder_pkg.sv
`default_nettype none
// adder_pkg: FSM encoding, default geometry and counter sizing shared by seq_adder_nbit.
// Rev 1.0
package adder_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_DIGIT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A single-slice adder still needs a 1-bit counter to keep the RTL uniform.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_adder_nbit_if.sv
`default_nettype none
// seq_adder_nbit_if: start/operand/result bundle; OVF exists only with SEQ_ADDER_OVF_EN.
// Rev 1.0
interface seq_adder_nbit_if #(
   parameter int WIDTH = adder_pkg::DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             C_in;
   logic [WIDTH-1:0] S;
   logic             C_out;
   logic             busy;
   logic             done;
`ifdef SEQ_ADDER_OVF_EN
   logic             OVF;
`endif

   modport master (
      output start, A, B, C_in,
      input  S, C_out, busy, done
`ifdef SEQ_ADDER_OVF_EN
      , input OVF
`endif
   );

   modport slave (
      input  start, A, B, C_in,
      output S, C_out, busy, done
`ifdef SEQ_ADDER_OVF_EN
      , output OVF
`endif
   );

endinterface
`default_nettype wire

// File: rtl/adder_digit.sv
`default_nettype none
// adder_digit: DIGIT-bit ripple of full adders with carry in and carry out.
// Rev 1.0
module adder_digit import adder_pkg::*; #(
   parameter int DIGIT = DEFAULT_DIGIT
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic [DIGIT-1:0] b_i,
   input  logic             c_i,
   output logic [DIGIT-1:0] s_o,
   output logic             c_o
);

   always_comb begin
      logic w_carry;
      w_carry = c_i;
      s_o     = '0;
      for (int i = 0; i < DIGIT; i++) begin
         s_o[i]  = a_i[i] ^ b_i[i] ^ w_carry;
         w_carry = (a_i[i] & b_i[i]) | (w_carry & (a_i[i] ^ b_i[i]));
      end
      c_o = w_carry;
   end

endmodule
`default_nettype wire

// File: rtl/seq_adder_nbit.sv
`default_nettype none
// seq_adder_nbit: digit-serial adder, one DIGIT-bit slice per clock, LS slice first.
// Build option SEQ_ADDER_OVF_EN adds a registered signed-overflow flag (OVF). Rev 1.0
module seq_adder_nbit import adder_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DIGIT = DEFAULT_DIGIT
) (
   input  logic            CLK,
   input  logic            RST_n,
   seq_adder_nbit_if.slave bus
);

   localparam int            N    = WIDTH / DIGIT;
   localparam int            CW   = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] s_q;
   logic             carry_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;
`ifdef SEQ_ADDER_OVF_EN
   logic             ovf_q;
`endif

   logic [DIGIT-1:0] w_a_slice;
   logic [DIGIT-1:0] w_b_slice;
   logic [DIGIT-1:0] w_sum;
   logic             w_cout;

   assign w_a_slice = a_q[cnt_q*DIGIT +: DIGIT];
   assign w_b_slice = b_q[cnt_q*DIGIT +: DIGIT];

   adder_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a_i (w_a_slice),
      .b_i (w_b_slice),
      .c_i (carry_q),
      .s_o (w_sum),
      .c_o (w_cout)
   );

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               // S/C_out are left alone here so results stay visible until new slices land.
               if (bus.start) begin
                  a_q     <= bus.A;
                  b_q     <= bus.B;
                  carry_q <= bus.C_in;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               s_q[cnt_q*DIGIT +: DIGIT] <= w_sum;
               carry_q                   <= w_cout;
               if (cnt_q == LAST) begin
                  cout_q  <= w_cout;
`ifdef SEQ_ADDER_OVF_EN
                  // Same-sign operands producing an opposite-sign result == carry-in(MSB) ^ carry-out.
                  ovf_q   <= (w_a_slice[DIGIT-1] == w_b_slice[DIGIT-1]) &&
                             (w_sum[DIGIT-1] != w_a_slice[DIGIT-1]);
`endif
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.S     = s_q;
   assign bus.C_out = cout_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
`ifdef SEQ_ADDER_OVF_EN
   assign bus.OVF   = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_adder_nbit.sv
`default_nettype none
// tb_seq_adder_nbit: scoreboard bench for seq_adder_nbit at DIGIT=4, plus DIGIT=1 and DIGIT=16 copies.
// OVF checks are compiled in when SEQ_ADDER_OVF_EN is defined. Rev 1.0
module tb_seq_adder_nbit;

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        ovf;
   } res_t;

   logic clk;
   logic rst_n;
   int   n_pass  = 0;
   int   n_total = 0;
   res_t q4[$];
   res_t q1[$];
   res_t q16[$];

   seq_adder_nbit_if #(.WIDTH(16)) bus4  ();
   seq_adder_nbit_if #(.WIDTH(16)) bus1  ();
   seq_adder_nbit_if #(.WIDTH(16)) bus16 ();

   seq_adder_nbit #(.WIDTH(16), .DIGIT(4))  u_dut4  (.CLK(clk), .RST_n(rst_n), .bus(bus4));
   seq_adder_nbit #(.WIDTH(16), .DIGIT(1))  u_dut1  (.CLK(clk), .RST_n(rst_n), .bus(bus1));
   seq_adder_nbit #(.WIDTH(16), .DIGIT(16)) u_dut16 (.CLK(clk), .RST_n(rst_n), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
      res_t        r;
      logic [16:0] t;
      t     = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      r.s   = t[15:0];
      r.c   = t[16];
      r.ovf = (a[15] == b[15]) && (t[15] != a[15]);
      return r;
   endfunction

   // Drives one start pulse on the DIGIT=4 copy, then scrambles operands so only the latched ones matter.
   task automatic issue4(input logic [15:0] a, input logic [15:0] b, input logic cin, input res_t exp);
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.A     = a;
      bus4.B     = b;
      bus4.C_in  = cin;
      q4.push_back(exp);
      @(negedge clk);
      bus4.start = 1'b0;
      bus4.A     = 16'($urandom);
      bus4.B     = 16'($urandom);
      bus4.C_in  = 1'($urandom);
   endtask

   // Waits (bounded) for done on the DIGIT=4 copy and pops the matching expectation.
   task automatic wait4(output res_t exp, output int lat, output int bcnt, output bit tmo);
      lat  = 0;
      bcnt = 0;
      tmo  = 1'b0;
      exp  = '0;
      while (bus4.done !== 1'b1 && lat < 40) begin
         if (bus4.busy === 1'b1) bcnt++;
         @(negedge clk);
         lat++;
      end
      if (bus4.done !== 1'b1 || q4.size() == 0) tmo = 1'b1;
      else exp = q4.pop_front();
   endtask

   task automatic test_reset();
      res_t e;
      int   lat, bc;
      bit   tmo;
      #3 rst_n = 1'b0;
      #1;
      n_total++; if (bus4.S !== 16'h0) $display("FAIL reset_S: got %h expected 0000", bus4.S); else n_pass++;
      n_total++; if (bus4.C_out !== 1'b0) $display("FAIL reset_Cout: got %b expected 0", bus4.C_out); else n_pass++;
      n_total++; if (bus4.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus4.busy); else n_pass++;
      n_total++; if (bus4.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus4.done); else n_pass++;
`ifdef SEQ_ADDER_OVF_EN
      n_total++; if (bus4.OVF !== 1'b0) $display("FAIL reset_OVF: got %b expected 0", bus4.OVF); else n_pass++;
`endif
      @(negedge clk);
      @(negedge clk);
      // Release and request in the same low phase: the very next edge must accept.
      rst_n      = 1'b1;
      bus4.start = 1'b1;
      bus4.A     = 16'h0F0F;
      bus4.B     = 16'h00F1;
      bus4.C_in  = 1'b0;
      q4.push_back('{s: 16'h1000, c: 1'b0, ovf: 1'b0});
      @(negedge clk);
      bus4.start = 1'b0;
      wait4(e, lat, bc, tmo);
      n_total++; if (tmo) $display("FAIL first_start_timeout: got no done expected done"); else n_pass++;
      n_total++; if (bus4.S !== e.s) $display("FAIL first_start_S: got %h expected %h", bus4.S, e.s); else n_pass++;
      n_total++; if (lat != 4) $display("FAIL first_start_latency: got %0d expected 4", lat); else n_pass++;
   endtask

   task automatic test_basic();
      res_t e;
      int   lat, bc;
      bit   tmo;
      issue4(16'h1234, 16'h4321, 1'b0, '{s: 16'h5555, c: 1'b0, ovf: 1'b0});
      wait4(e, lat, bc, tmo);
      n_total++; if (tmo) $display("FAIL basic_timeout: got no done expected done"); else n_pass++;
      n_total++; if (bus4.S !== e.s) $display("FAIL basic_S: got %h expected %h", bus4.S, e.s); else n_pass++;
      n_total++; if (bus4.C_out !== e.c) $display("FAIL basic_Cout: got %b expected %b", bus4.C_out, e.c); else n_pass++;
      n_total++; if (lat != 4) $display("FAIL basic_latency: got %0d expected 4", lat); else n_pass++;
      n_total++; if (bc != 4) $display("FAIL basic_busy_cycles: got %0d expected 4", bc); else n_pass++;
      n_total++; if (bus4.busy !== 1'b0) $display("FAIL basic_busy_in_done: got %b expected 0", bus4.busy); else n_pass++;
      @(negedge clk);
      n_total++; if (bus4.done !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", bus4.done); else n_pass++;
      n_total++; if (bus4.S !== e.s) $display("FAIL basic_S_hold: got %h expected %h", bus4.S, e.s); else n_pass++;
   endtask

   task automatic test_carry();
      res_t e;
      int   lat, bc;
      bit   tmo;
      issue4(16'hFFFF, 16'h0001, 1'b0, '{s: 16'h0000, c: 1'b1, ovf: 1'b0});
      wait4(e, lat, bc, tmo);
      n_total++; if (tmo) $display("FAIL carry1_timeout: got no done expected done"); else n_pass++;
      n_total++; if (bus4.S !== e.s) $display("FAIL carry1_S: got %h expected %h", bus4.S, e.s); else n_pass++;
      n_total++; if (bus4.C_out !== e.c) $display("FAIL carry1_Cout: got %b expected %b", bus4.C_out, e.c); else n_pass++;
      issue4(16'h0000, 16'hFFFF, 1'b1, '{s: 16'h0000, c: 1'b1, ovf: 1'b0});
      wait4(e, lat, bc, tmo);
      n_total++; if (tmo) $display("FAIL carry2_timeout: got no done expected done"); else n_pass++;
      n_total++; if (bus4.S !== e.s) $display("FAIL carry2_S: got %h expected %h", bus4.S, e.s); else n_pass++;
      n_total++; if (bus4.C_out !== e.c) $display("FAIL carry2_Cout: got %b expected %b", bus4.C_out, e.c); else n_pass++;
   endtask

`ifdef SEQ_ADDER_OVF_EN
   task automatic test_ovf();
      res_t e;
      int   lat, bc;
      bit   tmo;
      issue4(16'h7FFF, 16'h0001, 1'b0, '{s: 16'h8000, c: 1'b0, ovf: 1'b1});
      wait4(e, lat, bc, tmo);
      n_total++; if (tmo) $display("FAIL ovf1_timeout: got no done expected done"); else n_pass++;
      n_total++; if (bus4.S !== e.s) $display("FAIL ovf1_S: got %h expected %h", bus4.S, e.s); else n_pass++;
      n_total++; if (bus4.C_out !== e.c) $display("FAIL ovf1_Cout: got %b expected %b", bus4.C_out, e.c); else n_pass++;
      n_total++; if (bus4.OVF !== e.ovf) $display("FAIL ovf1_OVF: got %b expected %b", bus4.OVF, e.ovf); else n_pass++;
      issue4(16'hFFFF, 16'hFFFF, 1'b0, '{s: 16'hFFFE, c: 1'b1, ovf: 1'b0});
      wait4(e, lat, bc, tmo);
      n_total++; if (tmo) $display("FAIL ovf2_timeout: got no done expected done"); else n_pass++;
      n_total++; if (bus4.S !== e.s) $display("FAIL ovf2_S: got %h expected %h", bus4.S, e.s); else n_pass++;
      n_total++; if (bus4.C_out !== e.c) $display("FAIL ovf2_Cout: got %b expected %b", bus4.C_out, e.c); else n_pass++;
      n_total++; if (bus4.OVF !== e.ovf) $display("FAIL ovf2_OVF: got %b expected %b", bus4.OVF, e.ovf); else n_pass++;
   endtask
`endif

   // start held high for 15 cycles with fresh operands every cycle: accepts land on cycles 0, 5, 10.
   task automatic test_back_to_back();
      res_t        e;
      logic [15:0] a, b;
      logic        cin;
      int          dones = 0;
      @(negedge clk);
      for (int k = 0; k <= 15; k++) begin
         if (k > 0) begin
            n_total++;
            if (bus4.done !== ((k % 5) == 0)) $display("FAIL b2b_done_k%0d: got %b expected %b", k, bus4.done, (k % 5) == 0);
            else n_pass++;
            n_total++;
            if (bus4.busy !== ((k % 5) != 0)) $display("FAIL b2b_busy_k%0d: got %b expected %b", k, bus4.busy, (k % 5) != 0);
            else n_pass++;
            if (bus4.done === 1'b1 && q4.size() > 0) begin
               e = q4.pop_front();
               dones++;
               n_total++; if (bus4.S !== e.s) $display("FAIL b2b_S_k%0d: got %h expected %h", k, bus4.S, e.s); else n_pass++;
               n_total++; if (bus4.C_out !== e.c) $display("FAIL b2b_Cout_k%0d: got %b expected %b", k, bus4.C_out, e.c); else n_pass++;
            end
         end
         a   = 16'($urandom);
         b   = 16'($urandom);
         cin = 1'($urandom);
         bus4.start = (k < 15);
         bus4.A     = a;
         bus4.B     = b;
         bus4.C_in  = cin;
         if (k < 15 && (k % 5) == 0) q4.push_back(model(a, b, cin));
         @(negedge clk);
      end
      bus4.start = 1'b0;
      n_total++; if (dones != 3) $display("FAIL b2b_done_count: got %0d expected 3", dones); else n_pass++;
      n_total++; if (q4.size() != 0) $display("FAIL b2b_leftover: got %0d expected 0", q4.size()); else n_pass++;
   endtask

   task automatic test_reset_mid();
      res_t        e;
      int          lat, bc;
      bit          tmo;
      bit          seen = 1'b0;
      logic [15:0] a, b;
      issue4(16'h1234, 16'h4321, 1'b0, '{s: 16'h5555, c: 1'b0, ovf: 1'b0});
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      q4.delete();
      n_total++; if (bus4.S !== 16'h0) $display("FAIL midrst_S: got %h expected 0000", bus4.S); else n_pass++;
      n_total++; if (bus4.C_out !== 1'b0) $display("FAIL midrst_Cout: got %b expected 0", bus4.C_out); else n_pass++;
      n_total++; if (bus4.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus4.busy); else n_pass++;
      n_total++; if (bus4.done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", bus4.done); else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus4.done === 1'b1 || bus4.busy === 1'b1) seen = 1'b1;
      end
      n_total++; if (seen) $display("FAIL midrst_no_done: got activity expected none"); else n_pass++;
      a = 16'($urandom);
      b = 16'($urandom);
      issue4(a, b, 1'b1, model(a, b, 1'b1));
      wait4(e, lat, bc, tmo);
      n_total++; if (tmo) $display("FAIL midrst_fresh_timeout: got no done expected done"); else n_pass++;
      n_total++; if (bus4.S !== e.s) $display("FAIL midrst_fresh_S: got %h expected %h", bus4.S, e.s); else n_pass++;
      n_total++; if (bus4.C_out !== e.c) $display("FAIL midrst_fresh_Cout: got %b expected %b", bus4.C_out, e.c); else n_pass++;
   endtask

   task automatic test_random();
      res_t        e;
      int          lat, bc;
      bit          tmo;
      logic [15:0] a, b;
      logic        cin;
      for (int k = 0; k < 8; k++) begin
         a   = 16'($urandom);
         b   = 16'($urandom);
         cin = 1'($urandom);
         issue4(a, b, cin, model(a, b, cin));
         wait4(e, lat, bc, tmo);
         n_total++; if (tmo) $display("FAIL rand%0d_timeout: got no done expected done", k); else n_pass++;
         n_total++; if (bus4.S !== e.s) $display("FAIL rand%0d_S: got %h expected %h", k, bus4.S, e.s); else n_pass++;
         n_total++; if (bus4.C_out !== e.c) $display("FAIL rand%0d_Cout: got %b expected %b", k, bus4.C_out, e.c); else n_pass++;
`ifdef SEQ_ADDER_OVF_EN
         n_total++; if (bus4.OVF !== e.ovf) $display("FAIL rand%0d_OVF: got %b expected %b", k, bus4.OVF, e.ovf); else n_pass++;
`endif
      end
   endtask

   // Same operands on the DIGIT=1 (16-cycle) and DIGIT=16 (1-cycle) copies.
   task automatic test_sweep();
      res_t        e;
      logic [15:0] a, b;
      logic        cin;
      int          lat1, lat16;
      bit          d1, d16;
      for (int k = 0; k < 6; k++) begin
         a   = (k == 0) ? 16'hFFFF : 16'($urandom);
         b   = (k == 0) ? 16'h0000 : 16'($urandom);
         cin = (k == 0) ? 1'b1     : 1'($urandom);
         @(negedge clk);
         bus1.start  = 1'b1; bus1.A  = a; bus1.B  = b; bus1.C_in  = cin;
         bus16.start = 1'b1; bus16.A = a; bus16.B = b; bus16.C_in = cin;
         q1.push_back(model(a, b, cin));
         q16.push_back(model(a, b, cin));
         @(negedge clk);
         bus1.start  = 1'b0;
         bus16.start = 1'b0;
         d1 = 1'b0; d16 = 1'b0; lat1 = 0; lat16 = 0;
         for (int c = 0; c < 40 && !(d1 && d16); c++) begin
            if (!d1 && bus1.done === 1'b1 && q1.size() > 0) begin
               d1 = 1'b1; lat1 = c; e = q1.pop_front();
               n_total++; if (bus1.S !== e.s) $display("FAIL sweep1_%0d_S: got %h expected %h", k, bus1.S, e.s); else n_pass++;
               n_total++; if (bus1.C_out !== e.c) $display("FAIL sweep1_%0d_Cout: got %b expected %b", k, bus1.C_out, e.c); else n_pass++;
            end
            if (!d16 && bus16.done === 1'b1 && q16.size() > 0) begin
               d16 = 1'b1; lat16 = c; e = q16.pop_front();
               n_total++; if (bus16.S !== e.s) $display("FAIL sweep16_%0d_S: got %h expected %h", k, bus16.S, e.s); else n_pass++;
               n_total++; if (bus16.C_out !== e.c) $display("FAIL sweep16_%0d_Cout: got %b expected %b", k, bus16.C_out, e.c); else n_pass++;
            end
            if (!(d1 && d16)) @(negedge clk);
         end
         n_total++; if (!d1 || lat1 != 16) $display("FAIL sweep1_%0d_latency: got %0d (done %b) expected 16", k, lat1, d1); else n_pass++;
         n_total++; if (!d16 || lat16 != 1) $display("FAIL sweep16_%0d_latency: got %0d (done %b) expected 1", k, lat16, d16); else n_pass++;
         q1.delete();
         q16.delete();
      end
   endtask

   initial begin
      rst_n = 1'b1;
      bus4.start  = 1'b0; bus4.A  = '0; bus4.B  = '0; bus4.C_in  = 1'b0;
      bus1.start  = 1'b0; bus1.A  = '0; bus1.B  = '0; bus1.C_in  = 1'b0;
      bus16.start = 1'b0; bus16.A = '0; bus16.B = '0; bus16.C_in = 1'b0;
      test_reset();
      test_basic();
      test_carry();
`ifdef SEQ_ADDER_OVF_EN
      test_ovf();
`endif
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_sweep();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
